// File: rtl/lcd_bus_scheduler.sv
// Arbitrates the 8080-style LCD write bus between a command source and a pixel streamer.
// Pixel frames are optionally aligned to the panel tearing signal (fmark).
module lcd_bus_scheduler #(
    parameter int WR_LO       = 1,
    parameter int WR_HI       = 1,
    parameter int FRAME_BYTES = 153600,
    parameter int CNT_W       = 18
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_frame_sync_en,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    input  logic       i_pix_valid,
    input  logic [7:0] i_pix_data,
    output logic       o_pix_ready,
    input  logic       i_lcd_fmark,
    output logic       o_lcd_wr,
    output logic       o_lcd_rs,
    output logic [7:0] o_lcd_data,
    output logic       o_frame_active,
    output logic       o_frame_done,
    output logic       o_fmark_overrun
);

    localparam int PH_MAX = (WR_LO > WR_HI) ? WR_LO : WR_HI;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  LO_LOAD  = PH_W'(WR_LO - 1);
    localparam logic [PH_W-1:0]  HI_LOAD  = PH_W'(WR_HI - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FMARK,
        S_FRAME
    } state_e;

    typedef enum logic [1:0] {
        E_IDLE,
        E_LO,
        E_HI
    } eng_e;

    state_e           state_q, state_d;
    eng_e             eng_q, eng_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             wr_q, wr_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             rdy_en_q;
    logic             fm_s1_q, fm_s2_q, fm_s3_q;

    logic eng_free;
    logic hi_end;
    logic fm_edge;
    logic fm_go;
    logic cmd_ready;
    logic pix_ready;
    logic cmd_acc;
    logic pix_acc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fm_s1_q  <= 1'b0;
            fm_s2_q  <= 1'b0;
            fm_s3_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            fm_s1_q  <= i_lcd_fmark;
            fm_s2_q  <= fm_s1_q;
            fm_s3_q  <= fm_s2_q;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        hi_end   = (eng_q == E_HI) && (ph_q == '0);
        eng_free = (eng_q == E_IDLE) || hi_end;
        fm_edge  = fm_s2_q & ~fm_s3_q;
        fm_go    = pend_q | fm_edge;

        cmd_ready = 1'b0;
        pix_ready = 1'b0;
        unique case (state_q)
            S_IDLE:       cmd_ready = eng_free;
            S_WAIT_FMARK: cmd_ready = eng_free & ~fm_go;
            S_FRAME:      pix_ready = eng_free & ~last_q;
            default:      cmd_ready = 1'b0;
        endcase
        cmd_ready = cmd_ready & rdy_en_q;
        pix_ready = pix_ready & rdy_en_q;

        cmd_acc = i_cmd_valid & cmd_ready;
        pix_acc = i_pix_valid & pix_ready;
    end

    // Write engine: one low phase then one high phase per accepted byte.
    always_comb begin
        eng_d  = eng_q;
        ph_d   = ph_q;
        wr_d   = wr_q;
        rs_d   = rs_q;
        data_d = data_q;

        unique case (eng_q)
            E_LO: begin
                if (ph_q == '0) begin
                    eng_d = E_HI;
                    ph_d  = HI_LOAD;
                    wr_d  = 1'b1;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            E_HI: begin
                if (ph_q == '0) begin
                    eng_d = E_IDLE;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            default: eng_d = E_IDLE;
        endcase

        if (cmd_acc || pix_acc) begin
            eng_d  = E_LO;
            ph_d   = LO_LOAD;
            wr_d   = 1'b0;
            rs_d   = cmd_acc ? i_cmd_rs : 1'b1;
            data_d = cmd_acc ? i_cmd_data : i_pix_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A waiting command always wins over starting a frame.
                if (!i_cmd_valid && i_pix_valid) begin
                    pend_d = 1'b0;
                    if (i_frame_sync_en) begin
                        state_d = S_WAIT_FMARK;
                    end else begin
                        state_d = S_FRAME;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end
                end
            end
            S_WAIT_FMARK: begin
                if (fm_edge) begin
                    pend_d = 1'b1;
                end
                if (fm_go && eng_free) begin
                    state_d = S_FRAME;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            S_FRAME: begin
                if (pix_acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        last_d = 1'b1;
                    end
                end
                if (fm_edge) begin
                    ovr_d = 1'b1;
                end
                if (last_q && hi_end) begin
                    state_d = S_IDLE;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            eng_q   <= E_IDLE;
            ph_q    <= '0;
            wr_q    <= 1'b1;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            eng_q   <= eng_d;
            ph_q    <= ph_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_cmd_ready     = cmd_ready;
    assign o_pix_ready     = pix_ready;
    assign o_lcd_wr        = wr_q;
    assign o_lcd_rs        = rs_q;
    assign o_lcd_data      = data_q;
    assign o_frame_active  = (state_q == S_FRAME);
    assign o_frame_done    = done_q;
    assign o_fmark_overrun = ovr_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler: cycle table plus frame-level sequences.
module tb_lcd_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic       fmark = 1'b0;
    logic       o_cmd_ready, o_pix_ready, o_lcd_wr, o_lcd_rs;
    logic [7:0] o_lcd_data;
    logic       o_frame_active, o_frame_done, o_fmark_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .WR_LO(1), .WR_HI(1), .FRAME_BYTES(4), .CNT_W(3)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_frame_sync_en(sync_en),
        .i_cmd_valid(cmd_valid),
        .i_cmd_rs(cmd_rs),
        .i_cmd_data(cmd_data),
        .o_cmd_ready(o_cmd_ready),
        .i_pix_valid(pix_valid),
        .i_pix_data(pix_data),
        .o_pix_ready(o_pix_ready),
        .i_lcd_fmark(fmark),
        .o_lcd_wr(o_lcd_wr),
        .o_lcd_rs(o_lcd_rs),
        .o_lcd_data(o_lcd_data),
        .o_frame_active(o_frame_active),
        .o_frame_done(o_frame_done),
        .o_fmark_overrun(o_fmark_overrun)
    );

    typedef struct packed {
        logic       sync_en;
        logic       cmd_v;
        logic       cmd_rs;
        logic [7:0] cmd_d;
        logic       pix_v;
        logic [7:0] pix_d;
        logic       fm;
        logic       e_wr;
        logic       e_rs;
        logic [7:0] e_data;
        logic       e_cr;
        logic       e_pr;
        logic       e_act;
        logic       e_done;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic s, input logic cv, input logic crs, input logic [7:0] cd,
        input logic pv, input logic [7:0] pd, input logic f,
        input logic wr, input logic rs, input logic [7:0] d,
        input logic cr, input logic pr, input logic act, input logic dn
    );
        vec_t v;
        v = '{s, cv, crs, cd, pv, pd, f, wr, rs, d, cr, pr, act, dn};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic frame_run(input logic [7:0] base, input bit cf, input bit cm, input bit fm);
        logic [8:0] exp_q[$];
        logic [8:0] got_q[$];
        int  idx, done_n, ovr_n, done_at, fm_cnt;
        bit  prev_wr, pacc, cacc, cm_raised;
        idx = 0; done_n = 0; ovr_n = 0; done_at = -1; fm_cnt = 0;
        prev_wr = 1'b1; cm_raised = 1'b0;
        if (cf) exp_q.push_back({1'b1, 8'hC3});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, base + 8'(i)});
        if (cm) exp_q.push_back({1'b0, 8'h5A});
        @(posedge clk); #1;
        sync_en = 1'b0;
        pix_valid = 1'b1;
        pix_data = base;
        if (cf) begin
            cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'hC3;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            pacc = pix_valid && o_pix_ready;
            cacc = cmd_valid && o_cmd_ready;
            if (prev_wr && !o_lcd_wr) got_q.push_back({o_lcd_rs, o_lcd_data});
            prev_wr = o_lcd_wr;
            if (o_frame_done) begin
                done_n++;
                done_at = got_q.size();
            end
            if (o_fmark_overrun) ovr_n++;
            @(posedge clk); #1;
            if (cacc) cmd_valid = 1'b0;
            if (pacc) begin
                idx++;
                if (idx >= 4) pix_valid = 1'b0;
                else pix_data = base + 8'(idx);
            end
            if (idx == 2 && cm && !cm_raised) begin
                cm_raised = 1'b1;
                cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h5A;
            end
            if (idx == 2 && fm && fm_cnt == 0) begin
                fmark = 1'b1; fm_cnt = 1;
            end else if (fm_cnt > 0 && fm_cnt < 3) begin
                fm_cnt++;
                if (fm_cnt == 3) fmark = 1'b0;
            end
        end
        chk("frame_bytes_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("frame_byte%0d", i), got_q[i], exp_q[i]);
        end
        chk("frame_done_count", done_n, 1);
        chk("frame_done_pos", done_at, 4 + int'(cf));
        chk("fmark_overrun_count", ovr_n, int'(fm));
        @(negedge clk);
        chk("frame_active_end", o_frame_active, 0);
    endtask

    initial begin
        tbl[0]  = mk(0,1,0,8'h2C,0,8'h00,0, 1,0,8'h00,1,0,0,0);
        tbl[1]  = mk(0,0,0,8'h00,0,8'h00,0, 0,0,8'h2C,0,0,0,0);
        tbl[2]  = mk(0,0,0,8'h00,0,8'h00,0, 1,0,8'h2C,1,0,0,0);
        tbl[3]  = mk(0,0,0,8'h00,0,8'h00,0, 1,0,8'h2C,1,0,0,0);
        tbl[4]  = mk(1,0,0,8'h00,1,8'h11,0, 1,0,8'h2C,1,0,0,0);
        tbl[5]  = mk(1,0,0,8'h00,1,8'h11,0, 1,0,8'h2C,1,0,0,0);
        tbl[6]  = mk(1,0,0,8'h00,1,8'h11,0, 1,0,8'h2C,1,0,0,0);
        tbl[7]  = mk(1,0,0,8'h00,1,8'h11,1, 1,0,8'h2C,1,0,0,0);
        tbl[8]  = mk(1,0,0,8'h00,1,8'h11,1, 1,0,8'h2C,1,0,0,0);
        tbl[9]  = mk(1,0,0,8'h00,1,8'h11,0, 1,0,8'h2C,0,0,0,0);
        tbl[10] = mk(1,0,0,8'h00,1,8'h11,0, 1,0,8'h2C,0,1,1,0);
        tbl[11] = mk(1,0,0,8'h00,1,8'h22,0, 0,1,8'h11,0,0,1,0);
        tbl[12] = mk(1,0,0,8'h00,1,8'h22,0, 1,1,8'h11,0,1,1,0);
        tbl[13] = mk(1,0,0,8'h00,1,8'h33,0, 0,1,8'h22,0,0,1,0);
        tbl[14] = mk(1,0,0,8'h00,1,8'h33,0, 1,1,8'h22,0,1,1,0);
        tbl[15] = mk(1,0,0,8'h00,1,8'h44,0, 0,1,8'h33,0,0,1,0);
        tbl[16] = mk(1,0,0,8'h00,1,8'h44,0, 1,1,8'h33,0,1,1,0);
        tbl[17] = mk(1,0,0,8'h00,0,8'h00,0, 0,1,8'h44,0,0,1,0);
        tbl[18] = mk(1,0,0,8'h00,0,8'h00,0, 1,1,8'h44,0,0,1,0);
        tbl[19] = mk(0,0,0,8'h00,0,8'h00,0, 1,1,8'h44,1,0,0,1);
        tbl[20] = mk(0,0,0,8'h00,0,8'h00,0, 1,1,8'h44,1,0,0,0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", o_lcd_wr, 1);
        chk("rst_rs", o_lcd_rs, 0);
        chk("rst_data", o_lcd_data, 8'h00);
        chk("rst_cmd_ready", o_cmd_ready, 0);
        chk("rst_pix_ready", o_pix_ready, 0);
        chk("rst_active", o_frame_active, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", o_cmd_ready, 1);
        chk("post_rst_pix_ready", o_pix_ready, 0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            sync_en   = tbl[i].sync_en;
            cmd_valid = tbl[i].cmd_v;
            cmd_rs    = tbl[i].cmd_rs;
            cmd_data  = tbl[i].cmd_d;
            pix_valid = tbl[i].pix_v;
            pix_data  = tbl[i].pix_d;
            fmark     = tbl[i].fm;
            @(negedge clk);
            chk($sformatf("v%0d_wr", i), o_lcd_wr, tbl[i].e_wr);
            chk($sformatf("v%0d_rs", i), o_lcd_rs, tbl[i].e_rs);
            chk($sformatf("v%0d_data", i), o_lcd_data, tbl[i].e_data);
            chk($sformatf("v%0d_cmd_ready", i), o_cmd_ready, tbl[i].e_cr);
            chk($sformatf("v%0d_pix_ready", i), o_pix_ready, tbl[i].e_pr);
            chk($sformatf("v%0d_active", i), o_frame_active, tbl[i].e_act);
            chk($sformatf("v%0d_done", i), o_frame_done, tbl[i].e_done);
            chk($sformatf("v%0d_overrun", i), o_fmark_overrun, 0);
        end

        frame_run(8'h60, 1'b1, 1'b1, 1'b0);
        frame_run(8'h80, 1'b0, 1'b0, 1'b1);

        @(posedge clk); #1;
        sync_en = 1'b0;
        pix_valid = 1'b1;
        pix_data = 8'hEE;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (!o_lcd_wr) seen = 1'b1;
            end
            chk("midframe_wr_low_seen", seen, 1);
        end
        #1;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk("async_rst_wr", o_lcd_wr, 1);
        chk("async_rst_data", o_lcd_data, 8'h00);
        chk("async_rst_rs", o_lcd_rs, 0);
        chk("async_rst_pix_ready", o_pix_ready, 0);
        chk("async_rst_active", o_frame_active, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        frame_run(8'hA0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
